uart_serialize: RTL and testbench
=================================

UART_SERIALIZE -- requirements
Module: uart_serialize

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter CLKS_PER_BIT SHALL default to 16 and give the clk cycles per serial bit; legal range is 1..65535.
REQ-003 Parameter FRAME_BITS SHALL default to 11 and give the frame width (start, 8 data, parity, stop).
REQ-004 Parameter IDLE_LEVEL SHALL default to 1'b1 and give the line level driven when no frame is in flight.
REQ-005 Port clk, input, 1 bit: system clock; all state SHALL change on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port frame_in, input, FRAME_BITS bits: frame from the encoder stage, LSB transmitted first.
REQ-008 Port frame_valid, input, 1 bit: frame_in holds a frame to send.
REQ-009 Port frame_ready, output, 1 bit: the block will accept frame_in on this edge.
REQ-010 Port tx_line, output, 1 bit: serial output line.
REQ-011 Port bit_strobe, output, 1 bit: one-cycle pulse in the first cycle of every transmitted bit.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse in the last cycle of the last bit of a frame; this is the encoder's "next" request.
REQ-013 Port busy, output, 1 bit: high while in SHIFT.

Function
REQ-014 The block SHALL implement two states, IDLE and SHIFT, with a baud counter (0..CLKS_PER_BIT-1), a bit index (0..FRAME_BITS-1) and a FRAME_BITS shift register.
REQ-015 A frame SHALL be accepted on a rising edge where frame_valid and frame_ready are both high; frame_in is captured on that edge and not sampled again for that frame.
REQ-016 frame_ready SHALL be high in IDLE, and also in SHIFT during the last cycle of bit FRAME_BITS-1; it SHALL be low in all other cycles.
REQ-017 On acceptance: next state SHIFT, bit index 0, baud counter 0, tx_line = frame_in[0] from the following cycle; latency from accepting edge to first bit on the line SHALL be exactly one cycle.
REQ-018 Each bit SHALL be held on tx_line for exactly CLKS_PER_BIT cycles; bit k SHALL equal captured frame bit k.
REQ-019 When the baud counter reaches CLKS_PER_BIT-1 it SHALL wrap to 0 and the bit index SHALL increment; the counter SHALL not wrap at any other value.
REQ-020 bit_strobe SHALL be high exactly in the cycle where the baud counter is 0 in SHIFT.
REQ-021 frame_done SHALL be high exactly in the cycle where the bit index is FRAME_BITS-1 and the baud counter is CLKS_PER_BIT-1.
REQ-022 At the end of the last bit with a frame accepted in the same cycle (back-to-back), the block SHALL stay in SHIFT and drive the new frame's bit 0 with no idle gap.
REQ-023 At the end of the last bit without acceptance, the block SHALL enter IDLE and drive IDLE_LEVEL from the next cycle.
REQ-024 frame_valid high while frame_ready is low SHALL be ignored and SHALL NOT disturb the frame in flight.
REQ-025 With CLKS_PER_BIT = 1, each bit SHALL last one cycle, bit_strobe SHALL be high every SHIFT cycle, and frame_done SHALL coincide with bit FRAME_BITS-1.
REQ-026 The block SHALL NOT recompute or check parity; frame_in bits are sent verbatim.

Reset
REQ-027 While rst_n is low the block SHALL immediately hold: state IDLE, counters 0, tx_line = IDLE_LEVEL, frame_ready 0, busy 0, bit_strobe 0, frame_done 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no completion pulse.
REQ-029 After rst_n deasserts, frame_ready SHALL go high on the first rising edge.

Verification
REQ-030 CLKS_PER_BIT=4, frame_in=11'h54B, one-cycle valid pulse while idle -> tx_line carries 1,1,0,1,0,0,1,0,1,0,1 for 4 cycles each starting one cycle after acceptance; 11 bit_strobe pulses; one frame_done; then tx_line=1 and busy=0.
REQ-031 CLKS_PER_BIT=4, frame_valid held high with 11'h54B then 11'h7FF -> second frame's bit 0 follows the first frame's bit 10 with no gap; frame_ready is high for exactly one cycle in between.
REQ-032 CLKS_PER_BIT=1, frame_in=11'h001 -> exactly 11 SHIFT cycles, tx_line 1 then ten 0s, frame_done on cycle 11.
REQ-033 rst_n pulsed low during bit 5 of a frame -> tx_line=1 immediately, no frame_done, frame_ready=1 on the first edge after release.
REQ-034 frame_valid toggled with changing frame_in during SHIFT -> transmitted bits match only the frame captured at acceptance.

Source files
------------

// File: rtl/uart_serialize.sv
// UART frame serializer: accepts a FRAME_BITS frame and shifts it out LSB
// first, CLKS_PER_BIT clocks per bit.
// Ports:
//   clk, rst_n             clock and async active-low reset
//   frame_in, frame_valid  frame offered by the encoder
//   frame_ready            the frame is taken on this edge
//   tx_line                serial line
//   bit_strobe, frame_done first cycle of each bit and last cycle of frame
//   busy                   a frame is being shifted
module uart_serialize #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FRAME_BITS   = 11,
  parameter logic        IDLE_LEVEL   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_BITS-1:0] frame_in,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  tx_line,
  output logic                  bit_strobe,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(FRAME_BITS - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  // Low during reset and until the first edge after release, so
  // frame_ready stays low while rst_n is held.
  logic                  live_q;

  logic bit_end;
  logic last;
  logic accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;

    bit_end = (cnt_q == CNT_MAX);
    last    = (state_q == S_SHIFT) && (idx_q == IDX_MAX) && bit_end;

    frame_ready = live_q && ((state_q == S_IDLE) || last);
    accept      = frame_ready && frame_valid;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          idx_d   = '0;
          sh_d    = frame_in;
        end
      end
      S_SHIFT: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_MAX) begin
            idx_d = '0;
            // Back-to-back frame: reload without leaving SHIFT.
            if (accept) begin
              sh_d = frame_in;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
            sh_d  = sh_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy       = (state_q == S_SHIFT);
    tx_line    = busy ? sh_q[0] : IDLE_LEVEL;
    bit_strobe = busy && (cnt_q == '0);
    frame_done = last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_serialize.sv
// Bench for uart_serialize: two instances (4 and 1 clocks per bit)
// checked every cycle against a frame-time model.
module tb_uart_serialize;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [10:0] fin [2];
  logic        fv  [2];
  logic        rdy [2];
  logic        tx  [2];
  logic        stb [2];
  logic        dn  [2];
  logic        bsy [2];

  always #5 clk = ~clk;

  uart_serialize #(
    .CLKS_PER_BIT(4),
    .FRAME_BITS(11),
    .IDLE_LEVEL(1'b1)
  ) dut4 (
    .clk(clk),
    .rst_n(rst_n),
    .frame_in(fin[0]),
    .frame_valid(fv[0]),
    .frame_ready(rdy[0]),
    .tx_line(tx[0]),
    .bit_strobe(stb[0]),
    .frame_done(dn[0]),
    .busy(bsy[0])
  );

  uart_serialize #(
    .CLKS_PER_BIT(1),
    .FRAME_BITS(11),
    .IDLE_LEVEL(1'b1)
  ) dut1 (
    .clk(clk),
    .rst_n(rst_n),
    .frame_in(fin[1]),
    .frame_valid(fv[1]),
    .frame_ready(rdy[1]),
    .tx_line(tx[1]),
    .bit_strobe(stb[1]),
    .frame_done(dn[1]),
    .busy(bsy[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a frame is a run of cpb*11 cycles; t counts cycles into it.
  int          cpb [2] = '{4, 1};
  bit          m_busy [2];
  int          m_t [2];
  logic [10:0] m_frame [2];
  bit          m_live [2];
  int          acc_cnt [2];
  int          done_cnt [2];
  int          stb_cnt [2];
  int          rdy_cnt [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_last(int i);
    return m_busy[i] && (m_t[i] == cpb[i] * 11 - 1);
  endfunction

  function automatic bit m_ready(int i);
    return m_live[i] && (!m_busy[i] || m_last(i));
  endfunction

  function automatic logic m_tx(int i);
    logic [10:0] f;
    f = m_frame[i];
    return m_busy[i] ? f[m_t[i] / cpb[i]] : 1'b1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0;
      m_t[i]    = 0;
      m_live[i] = 1'b0;
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0;
      stb_cnt[i]  = 0;
      rdy_cnt[i]  = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rdy%0d", i), rdy[i], m_ready(i));
      chk($sformatf("tx%0d", i), tx[i], m_tx(i));
      chk($sformatf("stb%0d", i), stb[i],
          m_busy[i] && (m_t[i] % cpb[i] == 0));
      chk($sformatf("done%0d", i), dn[i], m_last(i));
      chk($sformatf("busy%0d", i), bsy[i], m_busy[i]);
      if (dn[i] === 1'b1) done_cnt[i]++;
      if (stb[i] === 1'b1) stb_cnt[i]++;
      if (rdy[i] === 1'b1) rdy_cnt[i]++;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        if (m_ready(i) && fv[i]) begin
          m_busy[i]  = 1'b1;
          m_t[i]     = 0;
          m_frame[i] = fin[i];
          acc_cnt[i]++;
        end else if (m_busy[i]) begin
          if (m_last(i)) m_busy[i] = 1'b0;
          else m_t[i]++;
        end
        m_live[i] = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    int start;
    int guard;
    for (int i = 0; i < 2; i++) begin
      fin[i] = '0;
      fv[i]  = 1'b0;
      acc_cnt[i] = 0;
      m_frame[i] = '0;
    end
    m_reset();
    clr_counts();
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_tx", tx[i], 1);
      chk("rst_rdy", rdy[i], 0);
      chk("rst_busy", bsy[i], 0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Single frame on each instance.
    clr_counts();
    fin[0] = 11'h54B;
    fin[1] = 11'h001;
    fv[0] = 1'b1;
    fv[1] = 1'b1;
    tick();
    fv[0] = 1'b0;
    fv[1] = 1'b0;
    fin[0] = 11'h2B4;
    fin[1] = 11'h7FE;
    repeat (4 * 11 + 3) tick();
    chk("done_cnt4", done_cnt[0], 1);
    chk("stb_cnt4", stb_cnt[0], 11);
    chk("done_cnt1", done_cnt[1], 1);
    chk("stb_cnt1", stb_cnt[1], 11);
    chk("idle_tx", tx[0], 1);
    chk("idle_busy", bsy[0], 0);

    // Back-to-back frames with valid held high.
    start = acc_cnt[0];
    fin[0] = 11'h54B;
    fv[0] = 1'b1;
    guard = 0;
    while (acc_cnt[0] == start && guard < 100) begin
      tick();
      guard++;
    end
    fin[0] = 11'h7FF;
    rdy_cnt[0] = 0;
    guard = 0;
    while (acc_cnt[0] == start + 1 && guard < 100) begin
      tick();
      guard++;
    end
    chk("b2b_timeout", guard < 100, 1);
    chk("b2b_rdy_cnt", rdy_cnt[0], 1);
    fv[0] = 1'b0;
    repeat (50) tick();

    // Reset in the middle of bit 5.
    fin[0] = 11'($urandom);
    fv[0] = 1'b1;
    tick();
    fv[0] = 1'b0;
    repeat (21) tick();
    clr_counts();
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("mid_rst_tx", tx[0], 1);
    chk("mid_rst_rdy", rdy[0], 0);
    chk("mid_rst_done", dn[0], 0);
    chk("mid_rst_busy", bsy[0], 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_rdy", rdy[0], 1);
    chk("rst_no_done", done_cnt[0], 0);

    // Random valid and frame traffic.
    repeat (3000) begin
      for (int i = 0; i < 2; i++) begin
        fv[i]  = ($urandom_range(0, 3) != 0);
        fin[i] = 11'($urandom);
      end
      tick();
    end
    chk("frames_seen4", acc_cnt[0] > 50, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
